// File: rtl/hmc_rx_rsp_extract.sv
// hmc_rx_rsp_extract: RX response extractor behind the openHMC AXI4-Stream master.
// It captures each accepted beat into a hold register and processes one flit per cycle.
// It tracks packet boundaries from the header and tail flags in TUSER.
// For every completed packet it pushes one response descriptor into a show-ahead FIFO.
// It also keeps saturating response and error counters.
// Ports:
//   clk_hmc, res_n_hmc          clock, asynchronous active-low reset
//   m_axis_rx_TVALID/TREADY     beat handshake (TREADY driven here)
//   m_axis_rx_TDATA/TUSER       beat payload; TUSER = {tail, header, flit valid} per flit
//   rsp_valid/rsp_ready         descriptor FIFO head valid / pop
//   rsp_cmd..rsp_seq_err        descriptor fields of the FIFO head
//   rsp_count, err_count        saturating descriptor / error counters
module hmc_rx_rsp_extract #(
  parameter int unsigned FPW            = 4,
  parameter int unsigned LOG_FPW        = 2,
  parameter int unsigned DWIDTH         = FPW*128,
  parameter int unsigned NUM_DATA_BYTES = FPW*16,
  parameter int unsigned LOG_FIFO_DEPTH = 3
) (
  input  logic                      clk_hmc,
  input  logic                      res_n_hmc,
  input  logic                      m_axis_rx_TVALID,
  output logic                      m_axis_rx_TREADY,
  input  logic [DWIDTH-1:0]         m_axis_rx_TDATA,
  input  logic [NUM_DATA_BYTES-1:0] m_axis_rx_TUSER,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [6:0]                rsp_cmd,
  output logic [4:0]                rsp_lng,
  output logic [10:0]               rsp_tag,
  output logic [6:0]                rsp_errstat,
  output logic                      rsp_dinv,
  output logic                      rsp_len_err,
  output logic                      rsp_seq_err,
  output logic [31:0]               rsp_count,
  output logic [31:0]               err_count
);

  localparam int unsigned FLIT_W = 128;
  localparam int unsigned LO_W   = 28;   // only flit bits [27:0] carry descriptor fields
  localparam int unsigned DEPTH  = 1 << LOG_FIFO_DEPTH;
  localparam int unsigned CNT_W  = 8;

  typedef struct packed {
    logic [6:0]  cmd;
    logic [4:0]  lng;
    logic [10:0] tag;
    logic [6:0]  errstat;
    logic        dinv;
    logic        len_err;
    logic        seq_err;
  } rsp_desc_t;

  // Hold register and flit walker
  logic                 rst_q;
  logic                 hold_vld;
  logic [LO_W-1:0]      hold_lo [FPW];
  logic [FPW-1:0]       hold_fv;
  logic [FPW-1:0]       hold_hdr;
  logic [FPW-1:0]       hold_tail;
  logic [LOG_FPW-1:0]   idx;

  // Open packet state
  logic                 in_pkt;
  logic                 seq_err_q;
  logic [6:0]           cmd_q;
  logic [4:0]           lng_q;
  logic [10:0]          tag_q;
  logic [CNT_W-1:0]     flit_cnt;

  // Descriptor FIFO
  rsp_desc_t            mem [DEPTH];
  logic [LOG_FIFO_DEPTH:0] wr_ptr;
  logic [LOG_FIFO_DEPTH:0] rd_ptr;

  logic [LO_W-1:0]      cur;
  logic                 cur_v, cur_hdr, cur_tail;
  logic                 last_idx, pkt_flit, push_req, stall, advance, orphan;
  logic                 push, pop, fifo_full, fifo_empty, accept;
  logic [CNT_W-1:0]     cnt_next;
  rsp_desc_t            desc;
  rsp_desc_t            head;
  logic                 unused_in;

  assign unused_in = ^{m_axis_rx_TDATA, m_axis_rx_TUSER};

  // Select the low bits of the flit currently addressed by idx
  always_comb begin
    cur = '0;
    for (int i = 0; i < FPW; i++) begin
      if (LOG_FPW'(i) == idx) cur = hold_lo[i];
    end
  end

  assign cur_v    = hold_vld && hold_fv[idx];
  assign cur_hdr  = cur_v && hold_hdr[idx];
  assign cur_tail = cur_v && hold_tail[idx];
  assign last_idx = (idx == LOG_FPW'(FPW-1));

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[LOG_FIFO_DEPTH] != rd_ptr[LOG_FIFO_DEPTH]) &&
                      (wr_ptr[LOG_FIFO_DEPTH-1:0] == rd_ptr[LOG_FIFO_DEPTH-1:0]);

  // A flit belongs to a packet if it opens one or one is already open
  assign pkt_flit = cur_v && (cur_hdr || in_pkt);
  assign orphan   = cur_v && !cur_hdr && !in_pkt;
  assign push_req = pkt_flit && cur_tail;
  assign stall    = push_req && fifo_full;
  assign advance  = hold_vld && !stall;
  assign push     = push_req && !fifo_full;
  assign pop      = !fifo_empty && rsp_ready;

  assign m_axis_rx_TREADY = rst_q && (!hold_vld || (last_idx && !stall));
  assign accept           = m_axis_rx_TVALID && m_axis_rx_TREADY;

  // Descriptor / packet state as it stands after the current flit
  always_comb begin
    if (cur_hdr)                   cnt_next = CNT_W'(1);
    else if (&flit_cnt)            cnt_next = flit_cnt;
    else                           cnt_next = flit_cnt + CNT_W'(1);
    desc.cmd     = cur_hdr ? cur[6:0]   : cmd_q;
    desc.lng     = cur_hdr ? cur[11:7]  : lng_q;
    desc.tag     = cur_hdr ? cur[22:12] : tag_q;
    desc.errstat = cur[26:20];
    desc.dinv    = cur[27];
    desc.seq_err = cur_hdr ? in_pkt : seq_err_q;
    desc.len_err = (cnt_next != CNT_W'(desc.lng));
  end

  // Reset-release qualifier for TREADY
  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc) rst_q <= 1'b0;
    else            rst_q <= 1'b1;
  end

  // Beat capture and flit index
  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc) begin
      hold_vld  <= 1'b0;
      hold_fv   <= '0;
      hold_hdr  <= '0;
      hold_tail <= '0;
      idx       <= '0;
      for (int i = 0; i < FPW; i++) hold_lo[i] <= '0;
    end else if (accept) begin
      hold_vld  <= 1'b1;
      hold_fv   <= m_axis_rx_TUSER[FPW-1:0];
      hold_hdr  <= m_axis_rx_TUSER[2*FPW-1:FPW];
      hold_tail <= m_axis_rx_TUSER[3*FPW-1:2*FPW];
      idx       <= '0;
      for (int i = 0; i < FPW; i++) hold_lo[i] <= m_axis_rx_TDATA[i*FLIT_W +: LO_W];
    end else if (advance) begin
      if (last_idx) hold_vld <= 1'b0;
      else          idx      <= idx + LOG_FPW'(1);
    end
  end

  // Open packet tracking; a tail closes the packet and clears the pending sequence error
  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc) begin
      in_pkt    <= 1'b0;
      seq_err_q <= 1'b0;
      cmd_q     <= '0;
      lng_q     <= '0;
      tag_q     <= '0;
      flit_cnt  <= '0;
    end else if (advance && pkt_flit) begin
      in_pkt    <= !cur_tail;
      seq_err_q <= cur_tail ? 1'b0 : desc.seq_err;
      cmd_q     <= desc.cmd;
      lng_q     <= desc.lng;
      tag_q     <= desc.tag;
      flit_cnt  <= cnt_next;
    end
  end

  // Descriptor FIFO
  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[LOG_FIFO_DEPTH-1:0]] <= desc;
        wr_ptr <= wr_ptr + (LOG_FIFO_DEPTH+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (LOG_FIFO_DEPTH+1)'(1);
    end
  end

  // Saturating counters
  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc) begin
      rsp_count <= '0;
      err_count <= '0;
    end else begin
      if (push && !(&rsp_count)) rsp_count <= rsp_count + 32'd1;
      if (((push && (desc.len_err || desc.seq_err)) || orphan) && !(&err_count))
        err_count <= err_count + 32'd1;
    end
  end

  assign head        = mem[rd_ptr[LOG_FIFO_DEPTH-1:0]];
  assign rsp_valid   = !fifo_empty;
  assign rsp_cmd     = head.cmd;
  assign rsp_lng     = head.lng;
  assign rsp_tag     = head.tag;
  assign rsp_errstat = head.errstat;
  assign rsp_dinv    = head.dinv;
  assign rsp_len_err = head.len_err;
  assign rsp_seq_err = head.seq_err;

endmodule

// File: tb/tb_hmc_rx_rsp_extract.sv
// Testbench for hmc_rx_rsp_extract (FPW=4): scoreboard of expected descriptors plus counter model.
module tb_hmc_rx_rsp_extract;

  localparam int unsigned FPW = 4;
  localparam int unsigned DW  = FPW*128;
  localparam int unsigned UW  = FPW*16;

  logic          clk_hmc = 1'b0;
  logic          res_n_hmc;
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic [UW-1:0] tuser;
  logic          rsp_valid, rsp_ready;
  logic [6:0]    rsp_cmd;
  logic [4:0]    rsp_lng;
  logic [10:0]   rsp_tag;
  logic [6:0]    rsp_errstat;
  logic          rsp_dinv, rsp_len_err, rsp_seq_err;
  logic [31:0]   rsp_count, err_count;

  hmc_rx_rsp_extract #(.FPW(4), .LOG_FPW(2), .LOG_FIFO_DEPTH(3)) dut (
    .clk_hmc          (clk_hmc),
    .res_n_hmc        (res_n_hmc),
    .m_axis_rx_TVALID (tvalid),
    .m_axis_rx_TREADY (tready),
    .m_axis_rx_TDATA  (tdata),
    .m_axis_rx_TUSER  (tuser),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_cmd          (rsp_cmd),
    .rsp_lng          (rsp_lng),
    .rsp_tag          (rsp_tag),
    .rsp_errstat      (rsp_errstat),
    .rsp_dinv         (rsp_dinv),
    .rsp_len_err      (rsp_len_err),
    .rsp_seq_err      (rsp_seq_err),
    .rsp_count        (rsp_count),
    .err_count        (err_count)
  );

  always #5 clk_hmc = ~clk_hmc;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [32:0] exp_q [$];
  int unsigned exp_rsp = 0;
  int unsigned exp_err = 0;

  logic [127:0] bf [FPW];
  logic [FPW-1:0] bv, bh, bt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] hdr_flit(input logic [6:0] cmd, input logic [4:0] lng,
                                            input logic [10:0] tag);
    logic [127:0] f;
    f = {$urandom, $urandom, $urandom, 32'h0};
    f[6:0] = cmd; f[11:7] = lng; f[22:12] = tag;
    return f;
  endfunction

  function automatic logic [127:0] tail_bits(input logic [127:0] base, input logic [6:0] es,
                                             input logic dinv);
    logic [127:0] f;
    f = base;
    f[26:20] = es; f[27] = dinv;
    return f;
  endfunction

  function automatic logic [32:0] mk_desc(input logic [127:0] hf, input logic [127:0] tf,
                                          input logic len_err, input logic seq_err);
    return {hf[6:0], hf[11:7], hf[22:12], tf[26:20], tf[27], len_err, seq_err};
  endfunction

  task automatic clr_beat();
    for (int i = 0; i < FPW; i++) bf[i] = {$urandom, $urandom, $urandom, $urandom};
    bv = '0; bh = '0; bt = '0;
  endtask

  task automatic put(input int i, input logic [127:0] f, input logic v, input logic h,
                     input logic t);
    bf[i] = f; bv[i] = v; bh[i] = h; bt[i] = t;
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge
  task automatic send_beat();
    int n;
    tdata  = {bf[3], bf[2], bf[1], bf[0]};
    tuser  = {52'({$urandom, $urandom}), bt, bh, bv};
    tvalid = 1'b1;
    n = 0;
    while (!tready && n < 100) begin
      @(negedge clk_hmc);
      n++;
    end
    if (!tready) check_eq("tready_timeout", 64'(tready), 64'd1);
    @(posedge clk_hmc);
    @(negedge clk_hmc);
    tvalid = 1'b0;
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_rsp_count"}, 64'(rsp_count), 64'(exp_rsp));
    check_eq({tag, "_err_count"}, 64'(err_count), 64'(exp_err));
  endtask

  // Scoreboard: compare the FIFO head whenever it is popped
  always @(negedge clk_hmc) begin
    if (res_n_hmc && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check_eq("unexpected_desc", 64'd1, 64'd0);
      else check_eq("desc", 64'({rsp_cmd, rsp_lng, rsp_tag, rsp_errstat, rsp_dinv,
                                 rsp_len_err, rsp_seq_err}), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    logic [127:0] h, t;
    res_n_hmc = 1'b0; tvalid = 1'b0; tdata = '0; tuser = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk_hmc);
    check_eq("rst_tready", 64'(tready), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_fields", 64'({rsp_cmd, rsp_lng, rsp_tag, rsp_errstat, rsp_dinv,
                                rsp_len_err, rsp_seq_err}), 64'd0);
    check_counts("rst");
    res_n_hmc = 1'b1;
    #1 check_eq("release_tready_low", 64'(tready), 64'd0);
    @(negedge clk_hmc);
    check_eq("release_tready_high", 64'(tready), 64'd1);
    rsp_ready = 1'b1;

    // Single-flit packet with latency check
    clr_beat();
    h = tail_bits(hdr_flit(7'h2F, 5'd1, 11'd5), 7'h00, 1'b0);
    put(0, h, 1, 1, 1);
    exp_q.push_back(mk_desc(h, h, 1'b0, 1'b0)); exp_rsp++;
    send_beat();
    check_eq("t1_not_yet_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk_hmc);
    check_eq("t1_valid", 64'(rsp_valid), 64'd1);
    check_eq("t1_rsp_count", 64'(rsp_count), 64'd1);
    repeat (6) @(negedge clk_hmc);

    // Two-beat packets: header on flit2, tail on flit3 of the next beat (6 flits)
    for (int k = 0; k < 2; k++) begin
      clr_beat();
      h = hdr_flit(7'h30, (k == 0) ? 5'd6 : 5'd5, 11'h1A3 + 11'(k));
      put(2, h, 1, 1, 0); put(3, bf[3], 1, 0, 0);
      send_beat();
      clr_beat();
      t = tail_bits(bf[3], 7'h2A, 1'b1);
      put(0, bf[0], 1, 0, 0); put(1, bf[1], 1, 0, 0); put(2, bf[2], 1, 0, 0);
      put(3, t, 1, 0, 1);
      exp_q.push_back(mk_desc(h, t, k == 1, 1'b0)); exp_rsp++;
      if (k == 1) exp_err++;
      send_beat();
    end
    repeat (8) @(negedge clk_hmc);
    check_counts("lng");

    // Second header before tail: first packet dropped, second flagged seq_err
    clr_beat();
    put(0, hdr_flit(7'h31, 5'd2, 11'd1), 1, 1, 0);
    h = hdr_flit(7'h32, 5'd2, 11'd2);
    put(1, h, 1, 1, 0);
    t = tail_bits(bf[2], 7'h11, 1'b0);
    put(2, t, 1, 0, 1);
    exp_q.push_back(mk_desc(h, t, 1'b0, 1'b1)); exp_rsp++; exp_err++;
    send_beat();
    repeat (8) @(negedge clk_hmc);
    check_counts("seq");

    // Orphan tail flit; an invalid flit with header/tail flags set is ignored
    clr_beat();
    put(0, tail_bits(bf[0], 7'h7F, 1'b1), 1, 0, 1);
    put(1, hdr_flit(7'h33, 5'd1, 11'd7), 0, 1, 1);
    exp_err++;
    send_beat();
    repeat (8) @(negedge clk_hmc);
    check_counts("orphan");
    check_eq("orphan_no_desc", 64'(rsp_valid), 64'd0);

    // FIFO full: nine single-flit packets with the consumer stalled
    rsp_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      clr_beat();
      h = tail_bits(hdr_flit(7'h40 + 7'(k), 5'd1, 11'd100 + 11'(k)), 7'(k), k[0]);
      put(0, h, 1, 1, 1);
      exp_q.push_back(mk_desc(h, h, 1'b0, 1'b0));
      send_beat();
    end
    repeat (6) @(negedge clk_hmc);
    check_eq("full_rsp_count", 64'(rsp_count), 64'(exp_rsp + 8));
    check_eq("full_tready_low", 64'(tready), 64'd0);
    check_eq("full_rsp_valid", 64'(rsp_valid), 64'd1);
    @(posedge clk_hmc); #1 rsp_ready = 1'b1;
    @(posedge clk_hmc); #1 rsp_ready = 1'b0;
    repeat (4) @(negedge clk_hmc);
    exp_rsp += 9;
    check_counts("full_after_pop");
    check_eq("full_tready_back", 64'(tready), 64'd1);
    rsp_ready = 1'b1;
    repeat (15) @(negedge clk_hmc);
    check_eq("full_drained", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a packet, then one fresh packet
    clr_beat();
    put(0, hdr_flit(7'h50, 5'd3, 11'd9), 1, 1, 0);
    put(1, bf[1], 1, 0, 0);
    put(2, tail_bits(bf[2], 7'h01, 1'b0), 1, 0, 1);
    send_beat();
    res_n_hmc = 1'b0;
    exp_rsp = 0; exp_err = 0;
    #1 check_counts("midrst");
    check_eq("midrst_tready", 64'(tready), 64'd0);
    repeat (3) @(negedge clk_hmc);
    res_n_hmc = 1'b1;
    #1 check_eq("midrst_release_tready_low", 64'(tready), 64'd0);
    @(negedge clk_hmc);
    clr_beat();
    h = tail_bits(hdr_flit(7'h51, 5'd1, 11'd11), 7'h05, 1'b1);
    put(0, h, 1, 1, 1);
    exp_q.push_back(mk_desc(h, h, 1'b0, 1'b0)); exp_rsp++;
    send_beat();
    repeat (8) @(negedge clk_hmc);
    check_counts("post_rst");
    check_eq("post_rst_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
